// File: rtl/draw_ball.sv
// draw_ball: overlays a filled circular ball on the background pixel stream.
// The ball position and visibility are latched once per frame, on the rising
// edge of vertical blanking. Every output has a fixed 3-cycle latency.
module draw_ball #(
  parameter int unsigned      RADIUS     = 32,
  parameter logic [11:0]      BALL_COLOR = 12'hFF0
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic        hsync_in,
  input  logic        hblnk_in,
  input  logic [10:0] vcount_in,
  input  logic        vsync_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [10:0] xpos_in,
  input  logic [10:0] ypos_in,
  input  logic        ball_en_in,
  output logic [10:0] hcount_out,
  output logic        hsync_out,
  output logic        hblnk_out,
  output logic [10:0] vcount_out,
  output logic        vsync_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);

  localparam logic [23:0] R2 = 24'(RADIUS * RADIUS);

  // Timing bundle packed as {hcount, hsync, hblnk, vcount, vsync, vblnk}
  localparam int unsigned TW = 26;

  // Frame latch state
  logic        vblnk_prev_q;
  logic [10:0] x_q, x_d;
  logic [10:0] y_q, y_d;
  logic        en_q, en_d;

  // Stage 1
  logic [TW-1:0]      tim1_q, tim1_d;
  logic [11:0]        rgb1_q;
  logic signed [11:0] dx1_q, dx1_d;
  logic signed [11:0] dy1_q, dy1_d;
  logic               blank1_q, blank1_d;
  logic               en1_q;

  // Stage 2
  logic [TW-1:0]      tim2_q;
  logic [11:0]        rgb2_q;
  logic [22:0]        dx2_q, dx2_d;
  logic [22:0]        dy2_q, dy2_d;
  logic               blank2_q;
  logic               en2_q;

  // Stage 3 (outputs)
  logic [TW-1:0]      tim3_q;
  logic [11:0]        rgb3_q, rgb3_d;

  logic signed [22:0] dx_ext;
  logic signed [22:0] dy_ext;
  logic [23:0]        dist2;
  logic               hit;

  // Frame latch next-state: capture requested position on vblnk rising edge
  always_comb begin
    x_d  = x_q;
    y_d  = y_q;
    en_d = en_q;
    if (vblnk_in && !vblnk_prev_q) begin
      x_d  = xpos_in;
      y_d  = ypos_in;
      en_d = ball_en_in;
    end
  end

  // Frame latch registers
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      vblnk_prev_q <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      en_q         <= 1'b0;
    end else begin
      vblnk_prev_q <= vblnk_in;
      x_q          <= x_d;
      y_q          <= y_d;
      en_q         <= en_d;
    end
  end

  // Stage 1 datapath: signed offsets from the latched centre
  always_comb begin
    tim1_d   = {hcount_in, hsync_in, hblnk_in, vcount_in, vsync_in, vblnk_in};
    dx1_d    = $signed({1'b0, hcount_in}) - $signed({1'b0, x_q});
    dy1_d    = $signed({1'b0, vcount_in}) - $signed({1'b0, y_q});
    blank1_d = hblnk_in | vblnk_in;
  end

  // Stage 2 datapath: squares; 23 bits hold 2047^2 exactly
  always_comb begin
    dx_ext = 23'(dx1_q);
    dy_ext = 23'(dy1_q);
    dx2_d  = $unsigned(dx_ext * dx_ext);
    dy2_d  = $unsigned(dy_ext * dy_ext);
  end

  // Stage 3 datapath: inclusive radius test and compositing
  always_comb begin
    dist2  = {1'b0, dx2_q} + {1'b0, dy2_q};
    hit    = en2_q & ~blank2_q & (dist2 <= R2);
    rgb3_d = hit ? BALL_COLOR : rgb2_q;
  end

  // Pipeline registers; timing and rgb travel alongside the arithmetic
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      tim1_q   <= '0;
      rgb1_q   <= '0;
      dx1_q    <= '0;
      dy1_q    <= '0;
      blank1_q <= 1'b0;
      en1_q    <= 1'b0;
      tim2_q   <= '0;
      rgb2_q   <= '0;
      dx2_q    <= '0;
      dy2_q    <= '0;
      blank2_q <= 1'b0;
      en2_q    <= 1'b0;
      tim3_q   <= '0;
      rgb3_q   <= '0;
    end else begin
      tim1_q   <= tim1_d;
      rgb1_q   <= rgb_in;
      dx1_q    <= dx1_d;
      dy1_q    <= dy1_d;
      blank1_q <= blank1_d;
      en1_q    <= en_q;
      tim2_q   <= tim1_q;
      rgb2_q   <= rgb1_q;
      dx2_q    <= dx2_d;
      dy2_q    <= dy2_d;
      blank2_q <= blank1_q;
      en2_q    <= en1_q;
      tim3_q   <= tim2_q;
      rgb3_q   <= rgb3_d;
    end
  end

  assign {hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out} = tim3_q;
  assign rgb_out = rgb3_q;

endmodule

// File: tb/tb_draw_ball.sv
// Directed bench for draw_ball: reset, latency, circle geometry, frame latch,
// edge clipping and blanking guard.
module tb_draw_ball;

  logic        pclk;
  logic        rst;
  logic [10:0] hcount_in;
  logic        hsync_in;
  logic        hblnk_in;
  logic [10:0] vcount_in;
  logic        vsync_in;
  logic        vblnk_in;
  logic [11:0] rgb_in;
  logic [10:0] xpos_in;
  logic [10:0] ypos_in;
  logic        ball_en_in;
  logic [10:0] hcount_out;
  logic        hsync_out;
  logic        hblnk_out;
  logic [10:0] vcount_out;
  logic        vsync_out;
  logic        vblnk_out;
  logic [11:0] rgb_out;

  int total = 0;
  int bad   = 0;

  localparam logic [11:0] BALL = 12'hFF0;
  localparam logic [11:0] BG   = 12'h0A5;

  draw_ball #(.RADIUS(32), .BALL_COLOR(12'hFF0)) dut (
    .pclk       (pclk),
    .rst        (rst),
    .hcount_in  (hcount_in),
    .hsync_in   (hsync_in),
    .hblnk_in   (hblnk_in),
    .vcount_in  (vcount_in),
    .vsync_in   (vsync_in),
    .vblnk_in   (vblnk_in),
    .rgb_in     (rgb_in),
    .xpos_in    (xpos_in),
    .ypos_in    (ypos_in),
    .ball_en_in (ball_en_in),
    .hcount_out (hcount_out),
    .hsync_out  (hsync_out),
    .hblnk_out  (hblnk_out),
    .vcount_out (vcount_out),
    .vsync_out  (vsync_out),
    .vblnk_out  (vblnk_out),
    .rgb_out    (rgb_out)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [10:0] h, input logic [10:0] v,
                       input logic hb, input logic vb, input logic [11:0] c);
    hcount_in = h;
    vcount_in = v;
    hblnk_in  = hb;
    vblnk_in  = vb;
    rgb_in    = c;
    hsync_in  = 1'b0;
    vsync_in  = 1'b0;
  endtask

  // Hold one pixel for three edges so it fills the pipeline, then check it
  task automatic check_pix(input string tag, input logic [10:0] h, input logic [10:0] v,
                           input logic hb, input logic vb, input logic [11:0] c,
                           input logic [11:0] exp);
    drive(h, v, hb, vb, c);
    repeat (3) tick();
    cmp({tag, "_rgb"}, 32'(rgb_out), 32'(exp));
    cmp({tag, "_h"},   32'(hcount_out), 32'(h));
  endtask

  // Produce one vblnk rising edge with the given request on the inputs
  task automatic latch(input logic [10:0] x, input logic [10:0] y, input logic en);
    drive(11'd0, 11'd770, 1'b0, 1'b0, 12'h000);
    tick();
    xpos_in    = x;
    ypos_in    = y;
    ball_en_in = en;
    vblnk_in   = 1'b1;
    tick();
    tick();
    vblnk_in   = 1'b0;
    tick();
  endtask

  initial begin
    rst        = 1'b0;
    xpos_in    = '0;
    ypos_in    = '0;
    ball_en_in = 1'b0;
    drive(11'd5, 11'd6, 1'b0, 1'b0, BG);
    #12;
    cmp("reset_rgb",    32'(rgb_out), 32'h0);
    cmp("reset_hcount", 32'(hcount_out), 32'h0);
    cmp("reset_vblnk",  32'(vblnk_out), 32'h0);
    @(negedge pclk);
    rst = 1'b1;

    // Ball disabled after reset even at latched (0,0)
    check_pix("first_frame", 11'd0, 11'd0, 1'b0, 1'b0, BG, BG);

    // Latency: output at edge i reflects input applied before edge i-2
    for (int i = 0; i < 12; i++) begin
      hcount_in = 11'(i + 10);
      vcount_in = 11'(3 * i);
      hsync_in  = i[1];
      vsync_in  = i[2];
      hblnk_in  = i[0];
      vblnk_in  = 1'b0;
      rgb_in    = BG;
      tick();
      if (i >= 2) begin
        cmp("lat_hcount", 32'(hcount_out), 32'(i - 2 + 10));
        cmp("lat_vcount", 32'(vcount_out), 32'(3 * (i - 2)));
        cmp("lat_hsync",  32'(hsync_out),  32'((i - 2) >> 1 & 1));
        cmp("lat_vsync",  32'(vsync_out),  32'((i - 2) >> 2 & 1));
        cmp("lat_hblnk",  32'(hblnk_out),  32'((i - 2) & 1));
        cmp("lat_rgb",    32'(rgb_out),    32'(BG));
      end
    end

    // Circle geometry around (100,200)
    latch(11'd100, 11'd200, 1'b1);
    xpos_in = 11'd500;
    ypos_in = 11'd500;
    check_pix("ctr",     11'd100, 11'd200, 1'b0, 1'b0, BG, BALL);
    check_pix("r_edge",  11'd132, 11'd200, 1'b0, 1'b0, BG, BALL);
    check_pix("r_out",   11'd133, 11'd200, 1'b0, 1'b0, BG, BG);
    check_pix("diag",    11'd123, 11'd223, 1'b0, 1'b0, BG, BG);
    check_pix("l_edge",  11'd68,  11'd200, 1'b0, 1'b0, BG, BALL);
    check_pix("l_out",   11'd67,  11'd200, 1'b0, 1'b0, BG, BG);
    check_pix("top",     11'd100, 11'd168, 1'b0, 1'b0, BG, BALL);
    check_pix("bot",     11'd100, 11'd232, 1'b0, 1'b0, BG, BALL);
    check_pix("bot_out", 11'd100, 11'd233, 1'b0, 1'b0, BG, BG);

    // Mid-frame request change is ignored until next vblnk edge
    check_pix("line400", 11'd10, 11'd400, 1'b0, 1'b0, BG, BG);
    xpos_in = 11'd300;
    ypos_in = 11'd200;
    check_pix("hold_old", 11'd100, 11'd200, 1'b0, 1'b0, BG, BALL);
    check_pix("hold_new", 11'd300, 11'd200, 1'b0, 1'b0, BG, BG);
    latch(11'd300, 11'd200, 1'b1);
    check_pix("upd_new", 11'd300, 11'd200, 1'b0, 1'b0, BG, BALL);
    check_pix("upd_old", 11'd100, 11'd200, 1'b0, 1'b0, BG, BG);

    // Edge clipping at origin, no wrap at far side
    latch(11'd0, 11'd0, 1'b1);
    check_pix("clip_0",    11'd0,    11'd0,  1'b0, 1'b0, BG, BALL);
    check_pix("clip_32",   11'd32,   11'd0,  1'b0, 1'b0, BG, BALL);
    check_pix("clip_33",   11'd33,   11'd0,  1'b0, 1'b0, BG, BG);
    check_pix("nowrap_h",  11'd1023, 11'd0,  1'b0, 1'b0, BG, BG);
    check_pix("nowrap_h2", 11'd2047, 11'd0,  1'b0, 1'b0, BG, BG);
    check_pix("nowrap_v",  11'd0,    11'd2040, 1'b0, 1'b0, BG, BG);

    // Disable request takes effect at next latch
    latch(11'd0, 11'd0, 1'b0);
    check_pix("disabled", 11'd0, 11'd0, 1'b0, 1'b0, BG, BG);

    // Blanking guard at bottom-right corner
    latch(11'd1023, 11'd767, 1'b1);
    check_pix("corner",   11'd1023, 11'd767, 1'b0, 1'b0, 12'h000, BALL);
    check_pix("hblank",   11'd1024, 11'd767, 1'b1, 1'b0, 12'h000, 12'h000);
    check_pix("hblank2",  11'd1023, 11'd767, 1'b1, 1'b0, 12'h123, 12'h123);
    check_pix("vblank",   11'd1023, 11'd768, 1'b0, 1'b1, 12'h000, 12'h000);
    vblnk_in = 1'b0;
    tick();
    check_pix("corner2",  11'd1000, 11'd767, 1'b0, 1'b0, 12'h000, BALL);

    // Asynchronous reset mid-stream
    drive(11'd1023, 11'd767, 1'b0, 1'b0, BG);
    hsync_in = 1'b1;
    repeat (3) tick();
    cmp("pre_rst_rgb", 32'(rgb_out), 32'(BALL));
    #2;
    rst = 1'b0;
    #1;
    cmp("async_rgb",   32'(rgb_out), 32'h0);
    cmp("async_hcnt",  32'(hcount_out), 32'h0);
    cmp("async_hsync", 32'(hsync_out), 32'h0);
    @(negedge pclk);
    rst = 1'b1;
    tick();
    tick();
    cmp("refill_2", 32'(hcount_out), 32'h0);
    tick();
    cmp("refill_h",     32'(hcount_out), 32'd1023);
    cmp("refill_hsync", 32'(hsync_out), 32'h1);
    cmp("refill_rgb",   32'(rgb_out), 32'(BG));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/draw_ball.md
Name: draw_ball

Overview:
- Overlay stage directly downstream of draw_background, in the 65 MHz pixel domain.
- Consumes the timing bundle and background RGB stream.
- Paints a filled circular ball of fixed radius centred at a frame-latched (x,y) position.
- Forwards the timing bundle delayed to match, toward the VGA output pins.
- Ball position is sampled once per frame at the start of vertical blanking, so the ball never tears mid-frame.

Parameters:
- RADIUS, 32, ball radius in pixels (1..255).
- BALL_COLOR, 12'hFF0, RGB444 fill colour of the ball.

Ports:
- pclk  input  1  pixel clock, 65 MHz
- rst  input  1  asynchronous, active-low reset
- hcount_in  input  11  horizontal pixel counter
- hsync_in  input  1  horizontal sync
- hblnk_in  input  1  horizontal blanking
- vcount_in  input  11  vertical line counter
- vsync_in  input  1  vertical sync
- vblnk_in  input  1  vertical blanking
- rgb_in  input  12  background pixel, RGB444
- xpos_in  input  11  requested ball centre x
- ypos_in  input  11  requested ball centre y
- ball_en_in  input  1  requested ball visibility
- hcount_out  output  11  hcount_in delayed 3 cycles
- hsync_out  output  1  hsync_in delayed 3 cycles
- hblnk_out  output  1  hblnk_in delayed 3 cycles
- vcount_out  output  11  vcount_in delayed 3 cycles
- vsync_out  output  1  vsync_in delayed 3 cycles
- vblnk_out  output  1  vblnk_in delayed 3 cycles
- rgb_out  output  12  composited pixel

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, all pipeline registers 0, latched xpos/ypos 0, latched ball_en 0, vblnk edge register 0. Release is synchronous to pclk via the upstream reset block.
- Frame latch:
  - vblnk_prev <= vblnk_in each cycle.
  - On the cycle with vblnk_in=1 and vblnk_prev=0, capture xpos_in, ypos_in and ball_en_in into x_q, y_q, en_q.
  - Inputs are ignored at all other times.
  - First frame after reset uses (0,0) with the ball disabled.
- Pipeline: fixed latency of 3 cycles for every output. Timing signals and rgb_in travel through a 3-deep register chain in parallel with the datapath.
  - S1: dx = hcount_in - x_q and dy = vcount_in - y_q, 12-bit signed, zero-extended operands. blank1 = hblnk_in | vblnk_in.
  - S2: dx2 = dx*dx and dy2 = dy*dy, 23-bit unsigned.
  - S3: hit = en_q(S2 copy) & ~blank2 & (dx2+dy2 <= RADIUS*RADIUS), sum 24-bit unsigned. rgb_out <= hit ? BALL_COLOR : rgb_in(delayed 2).
- Inclusive boundary: pixels at exactly distance RADIUS along an axis are painted.
- No wrap-around: a ball near the screen edge is clipped naturally, because negative dx/dy square to large positive values.
- en_q is copied into the pipeline at S1, so a latch update during blanking cannot split a pixel's evaluation.
- Blanking: rgb_out is rgb_in delayed, never BALL_COLOR, even if the circle overlaps blanking coordinates.
- Simultaneous events: a position change on the latch cycle is captured. The latch cycle's own pixel is blanked, so there is no visible effect.
- Reset mid-frame clears everything immediately. The output shows black/sync-low until the pipeline refills 3 cycles after release.

Test Plan:
1. Reset mid-operation: pulse rst=0 while streaming → all outputs 0 asynchronously. 3 cycles after release, outputs track inputs again with 3-cycle delay.
2. Latency/passthrough: ball_en_in=0, ramp hcount_in/vcount_in, hsync_in pattern, rgb_in=12'h0A5 → every *_out equals its input 3 cycles earlier; rgb_out=12'h0A5.
3. Circle geometry: xpos_in=100, ypos_in=200, ball_en_in=1, latched at a vblnk rising edge, RADIUS=32. In the following frame:
   - pixel (100,200) → 12'hFF0
   - pixel (132,200) → 12'hFF0 (1024≤1024)
   - pixel (133,200) → background
   - pixel (123,223) → background (1058>1024)
   - pixel (68,200) → 12'hFF0
4. Frame-synchronous update: change xpos_in 100→300 at line 400 of the active area → pixel (100,200) stays ball for the rest of the frame. After the next vblnk rising edge, pixel (300,200) is the ball and pixel (100,200) is background.
5. Edge clipping: latch xpos=0, ypos=0 → pixel (0,0) and (32,0) painted; (33,0) background. No ball pixels near hcount=1023 (no wrap).
6. Blanking guard: ball centred at (1023,767), visible region only → pixels with hblnk_in or vblnk_in=1 output the delayed rgb_in (0). Pixel (1023,767) in active area = 12'hFF0.
